// File: rtl/swcap_pkg.sv
// Shared constants for the switch/key capture responder: register map and bus widths.
package swcap_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd2;

endpackage : swcap_pkg

// File: rtl/avalon_switch_capture_if.sv
// Avalon-MM responder bus (fixed read latency 1, no waitrequest).
interface avalon_switch_capture_if;
  import swcap_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );

endinterface : avalon_switch_capture_if

// File: rtl/swcap_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a tick-sampled debounce counter.
// toggle is combinational and marks the clock edge on which deb flips.
module swcap_debounce_bit #(
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic deb,
  output logic toggle
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  assign differ = sync_q[1] ^ deb;
  assign toggle = differ & tick & (cnt == CNT_W'(STABLE_TICKS - 1));

  // Sync flops reset to 0 alongside deb, so releasing reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      deb    <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (!differ) begin
        cnt <= '0;
      end else if (toggle) begin
        deb <= ~deb;
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : swcap_debounce_bit

// File: rtl/avalon_switch_capture.sv
// Avalon-MM switch/key capture: debounced level, sticky edge capture, optional interrupt.
// Build option: define SWCAP_IRQ_EN to implement the MASK register and the irq output.
module avalon_switch_capture
  import swcap_pkg::*;
#(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_switch_capture_if.slave bus,
  input  logic [WIDTH-1:0]       sw_in,
  output logic                   irq
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic             wr_en;
  logic             wr_edge;
  logic [DATA_W-1:0] rd_next;

  assign rd_en   = bus.chipselect & bus.read;
  assign wr_en   = bus.chipselect & bus.write;
  assign wr_edge = wr_en & (bus.address == ADDR_EDGE);
  assign wdata   = bus.writedata[WIDTH-1:0];

  if (WIDTH < DATA_W) begin : g_wdata_upper
    logic unused_wdata_upper;
    assign unused_wdata_upper = ^bus.writedata[DATA_W-1:WIDTH];
  end

  // Debounce sample prescaler, one-cycle tick at the terminal count.
  assign tick = (presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    swcap_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .raw    (sw_in[i]),
      .deb    (deb[i]),
      .toggle (toggle[i])
    );
  end

  // Sticky edge capture; a new edge overrides a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
    end else if (wr_edge) begin
      edge_cap <= (edge_cap & ~wdata) | toggle;
    end else begin
      edge_cap <= edge_cap | toggle;
    end
  end

`ifdef SWCAP_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_en && (bus.address == ADDR_MASK)) begin
        mask <= wdata;
      end
      irq <= |(edge_cap & mask);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  // Read mux uses pre-update register values, so same-cycle writes read back old data.
  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA: rd_next = DATA_W'(deb);
      ADDR_MASK: rd_next = DATA_W'(mask);
      ADDR_EDGE: rd_next = DATA_W'(edge_cap);
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else if (rd_en) begin
      bus.readdata <= rd_next;
    end
  end

endmodule : avalon_switch_capture

// File: tb/tb_avalon_switch_capture.sv
// Scoreboarded bench for avalon_switch_capture (WIDTH=10, TICK_DIV=4, STABLE_TICKS=3).
// Reads push expectations; a monitor pops and compares when read data becomes valid.
module tb_avalon_switch_capture;
  import swcap_pkg::*;

  localparam int unsigned W  = 10;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;

`ifdef SWCAP_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic         irq;

  avalon_switch_capture_if bus ();

  avalon_switch_capture #(
    .WIDTH        (W),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave),
    .sw_in (sw_in),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc;
  logic        rd_d;
  logic [31:0] exp_q[$];
  string       name_q[$];

  // Edges counted since reset release; debounce ticks act on edges that are multiples of TD.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc  <= 0;
      rd_d <= 1'b0;
    end else begin
      cyc  <= cyc + 1;
      rd_d <= bus.chipselect & bus.read;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", bus.readdata);
      end else begin
        check(name_q.pop_front(), bus.readdata, exp_q.pop_front());
      end
    end
  end

  // Bus tasks start just after a negedge and return at the next negedge.
  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic bus_rw(input logic [1:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_tick;
    for (int k = 0; k < 2 * TD && (cyc % TD) != 0; k++) @(negedge clk);
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;

    // Reset state
    cycles(3);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    bus_read(ADDR_DATA, 32'h000, "rst_data");
    bus_read(ADDR_EDGE, 32'h000, "rst_edge");
    bus_read(2'd3, 32'h000, "reserved");

    // bit3 rise: deb flips on edge e0+12 when the change follows edge e0
    align_tick();
    sw_in[3] = 1'b1;
    cycles(9);
    bus_read(ADDR_DATA, 32'h000, "rise_early");
    cycles(4);
    bus_read(ADDR_DATA, 32'h008, "rise_data");
    bus_read(ADDR_EDGE, 32'h008, "rise_edge");

    // bit5 glitch shorter than 3 ticks is rejected
    align_tick();
    sw_in[5] = 1'b1;
    cycles(6);
    sw_in[5] = 1'b0;
    cycles(16);
    bus_read(ADDR_DATA, 32'h008, "glitch_data");
    bus_read(ADDR_EDGE, 32'h008, "glitch_edge");

    // DATA is read-only; W1C on EDGE; read+write returns old value
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA, 32'h008, "data_ro");
    bus_rw(ADDR_EDGE, 32'h0000_0008, 32'h008, "rw_old");
    bus_read(ADDR_EDGE, 32'h000, "w1c_edge");

    // bit3 fall toggles on e0+12 while a W1C of bit3 lands on the same edge
    align_tick();
    sw_in[3] = 1'b0;
    cycles(11);
    bus_write(ADDR_EDGE, 32'h0000_0008);
    bus_read(ADDR_EDGE, 32'h008, "set_wins");
    bus_read(ADDR_DATA, 32'h000, "fall_data");

    // Mask and interrupt
    bus_write(ADDR_EDGE, 32'hFFFF_FFFF);
    bus_read(ADDR_EDGE, 32'h000, "clear_all");
    bus_write(ADDR_MASK, 32'hFFFF_FFFF);
    bus_read(ADDR_MASK, IRQ_ON ? 32'h3FF : 32'h0, "mask_width");
    bus_write(ADDR_MASK, 32'h0000_0001);
    bus_read(ADDR_MASK, IRQ_ON ? 32'h001 : 32'h0, "mask_rd");
    align_tick();
    sw_in[0] = 1'b1;
    cycles(12);
    check("irq_before", 32'(irq), 32'h0);
    cycles(1);
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    bus_write(ADDR_EDGE, 32'h0000_0001);
    check("irq_hold", 32'(irq), 32'(IRQ_ON));
    cycles(1);
    check("irq_clear", 32'(irq), 32'h0);
    bus_write(ADDR_MASK, 32'h0);
    align_tick();
    sw_in[0] = 1'b0;
    cycles(16);
    check("irq_masked", 32'(irq), 32'h0);
    bus_read(ADDR_EDGE, 32'h001, "masked_edge");

    // Reset mid-count with bit2 held high, preceded by nonzero readdata and irq
    bus_write(ADDR_MASK, 32'h0000_0001);
    bus_read(ADDR_EDGE, 32'h001, "pre_rst_edge");
    cycles(1);
    check("pre_rst_irq", 32'(irq), 32'(IRQ_ON));
    sw_in[2] = 1'b1;
    cycles(5);
    rst = 1'b1;
    #1;
    check("midrst_readdata", bus.readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    cycles(3);
    rst = 1'b0;
    bus_read(ADDR_EDGE, 32'h000, "post_rst_edge");
    bus_read(ADDR_MASK, 32'h000, "post_rst_mask");
    cycles(8);
    bus_read(ADDR_EDGE, 32'h000, "reaccept_early");
    cycles(1);
    bus_read(ADDR_EDGE, 32'h004, "reaccept_edge");
    bus_read(ADDR_DATA, 32'h004, "reaccept_data");

    cycles(3);
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_avalon_switch_capture

// File: doc/avalon_switch_capture.md
Name: avalon_switch_capture

Overview:
- Avalon-MM responder that the Nios II initiator reads to sample the board slide switches and keys.
- Synchronises and debounces each input bit, then exposes three things: debounced level, per-bit edge capture, and an optional maskable interrupt.
- Sits inside the Nios system as the input-side peripheral, alongside the HEX/LED output PIOs. Timekeeping firmware polls it or takes interrupts from it to set the clock.

Parameters:
- WIDTH, 10: number of input bits (1..32).
- TICK_DIV, 50000: clk cycles per debounce sample tick (>=2). 1 ms at 50 MHz.
- STABLE_TICKS, 8: consecutive ticks an input must differ from its debounced value before the new value is accepted (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  word register index
- chipselect  in  1  responder select
- read  in  1  read strobe, valid with chipselect
- write  in  1  write strobe, valid with chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- sw_in  in  WIDTH  raw asynchronous switch/key inputs
- irq  out  1  level interrupt; only functional under the optional macro

Behaviour:
- Reset (asynchronous, active-high):
  - readdata = 0, irq = 0.
  - Sync flops, debounced state `deb`, edge register, mask, prescaler and all per-bit counters = 0.
- Synchroniser: 2-flop per bit, producing `sync`. No reset-release glitch is allowed to create an edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is a one-cycle pulse when the count equals TICK_DIV-1.
- Per-bit debounce counter, width clog2(STABLE_TICKS+1):
  - If sync == deb: counter cleared on any cycle.
  - Else, on a tick: if counter == STABLE_TICKS-1, deb bit toggles and counter clears; otherwise counter increments.
  - A bounce that returns to deb before acceptance clears the count.
  - Worst-case accept latency is 2 + STABLE_TICKS*TICK_DIV cycles.
- Edge register (edge_cap):
  - A bit is set on the same clock edge its deb bit toggles, on both rising and falling transitions.
  - Bits are sticky.
- Register map (word addresses):
  - 0 DATA: RO, {0, deb}. Writes are ignored.
  - 1 MASK: RW, WIDTH bits. Upper bits read 0.
  - 2 EDGE: read returns edge_cap. Write-1-to-clear per bit.
  - 3 reserved: reads 0, writes ignored.
- Read timing:
  - Fixed read latency of 1. readdata is registered on the cycle chipselect&read is high, and valid the following cycle.
  - readdata holds its value until the next read.
  - No waitrequest.
- Write timing: takes effect on the clock edge where chipselect&write is high.
- Simultaneous events:
  - A new edge and a W1C of the same bit in the same cycle leave the bit set (set wins).
  - A read of EDGE in the same cycle as a set returns the pre-update value.
  - Simultaneous read and write to the same address returns the old value.
- Width rules: writedata bits above WIDTH are ignored. readdata bits above WIDTH are 0.
- Reset mid-debounce: the count is abandoned. An input held high through reset is re-accepted as a rising edge STABLE_TICKS ticks after release.

Optional Feature:
- Macro: SWCAP_IRQ_EN.
- Defined:
  - MASK register is implemented.
  - irq is registered and equals |(edge_cap & mask). It asserts one cycle after the edge bit sets and deasserts one cycle after clearing.
- Undefined:
  - No MASK storage; MASK reads 0 and writes are ignored.
  - irq is tied 0.

Decomposition:
- Package swcap_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2;
  - the readdata width constant 32.
- One natural sub-module, swcap_debounce_bit: per-bit synchroniser plus debounce counter, with inputs clk, reset, tick and raw, and outputs deb and toggle. It is instantiated WIDTH times by generate.

Test Plan (run with TICK_DIV=4, STABLE_TICKS=3, WIDTH=10):
- Reset → readdata=0, irq=0. Read DATA → 0x000; read EDGE → 0x000.
- sw_in[3] rises and is held 20 cycles → DATA reads 0x008 within 2+12 cycles and not before 2+8. EDGE reads 0x008.
- sw_in[5] pulses high for 6 cycles (fewer than 3 ticks) → DATA bit5 stays 0, EDGE bit5 stays 0.
- With EDGE=0x008: write EDGE 0x008 → reads 0x000. Then an edge on bit3 arrives in the same cycle as a W1C of bit3 → bit3 reads 1.
- SWCAP_IRQ_EN: MASK=0x001, toggle sw_in[0] → irq=1 one cycle after EDGE bit0 sets. Write EDGE 0x001 → irq=0 next cycle. MASK=0 with the edge pending → irq stays 0.
- Reset asserted mid-count with sw_in[2]=1 → all registers 0 immediately. After release, EDGE bit2 sets after 3 ticks.
